pipe_addsub: RTL and testbench
==============================

# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor for the 18-bit datapath and wider successors. It accepts one operation per cycle on a valid/ready handshake and splits the operand width into fixed-width segments, one segment per pipeline stage. Each stage forwards a registered carry to the next stage, so the critical path is one segment wide. It produces sum, carry/borrow and status flags, and sits between the operand registers and the ALU result mux.

## Interface
Parameters:
- WIDTH, default 18: operand and result width. Must be ≥ 2.
- SEG_W, default 6: bits added per stage. Must satisfy 1 ≤ SEG_W ≤ WIDTH.
- STAGES (derived, not overridable) = ceil(WIDTH/SEG_W). This is also the latency.

Ports:
- clk  in  1  single clock. All state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  1  0 = ADD, 1 = SUB.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in for ADD, borrow-in for SUB (multiword chaining).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out for ADD; NOT borrow for SUB (1 = no borrow).
- out_ovf  out  1  signed overflow.
- out_z  out  1  result is zero.
- out_n  out  1  result MSB.

## Operation
- ADD computes A + B + in_cin.
- SUB computes A + ~B + ~in_cin, i.e. A − B − in_cin.
- Segment k covers bits [k·SEG_W +: SEG_W]. The last segment is WIDTH − (STAGES−1)·SEG_W bits wide when WIDTH is not a multiple of SEG_W.
- Stage k adds segment k using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Upper operand segments travel in the pipeline registers alongside the data. Finished lower sum segments accumulate in those registers.
- Results are exact modulo 2^WIDTH.
- out_cout is the carry out of bit WIDTH−1.
- out_ovf = carry into MSB XOR carry out of MSB.
- Each stage has its own valid bit.
- Stall rule: stall = out_valid & ~out_ready. On stall every stage holds.
- in_ready = ~stall. This is combinational from out_valid and out_ready and never depends on in_valid.
- Operations are never reordered, dropped or duplicated.

## Timing
- Reset (async assert, sync release): all stage valids = 0, out_valid = 0, out_sum = 0, out_cout = out_ovf = out_z = out_n = 0.
- In reset, in_ready = 1. It is not gated by reset.
- Latency: an operation accepted on edge t presents out_valid = 1 with its result after edge t+STAGES−1. For STAGES = 1 the result is registered once.
- Throughput: one operation per cycle while out_ready = 1.
- Outputs hold stable while out_valid & ~out_ready.
- Bubbles (in_valid = 0) propagate as invalid stages and never block later operations.
- Simultaneous events: accept-on-input and release-on-output in the same cycle are both legal.
- Reset asserted mid-stream discards all in-flight operations immediately.

## Configuration
- PIPE_ADDSUB_FLAGS_EN defined: out_z and out_n are computed from the final sum in the last stage and registered alongside out_sum.
- PIPE_ADDSUB_FLAGS_EN undefined: out_z and out_n are tied to 0 and no zero-detect logic exists.
- The port list is identical in both cases.
- out_ovf and out_cout are always present.

## Structure
- Shared package pipe_addsub_pkg holds:
  - op typedef (OP_ADD = 0, OP_SUB = 1)
  - a stages_f(width, seg_w) function for the ceil division.
- One sub-module, addsub_seg:
  - combinational SEG_W-wide add of a, b and cin to sum and cout
  - instantiated STAGES times by a generate loop
  - pipeline registers and handshake logic stay in pipe_addsub.

## Test plan
Defaults unless stated: WIDTH = 18, SEG_W = 6, latency 3.
- Reset: hold rst_n = 0 with in_valid = 1 → out_valid = 0, out_sum = 0, all flags 0. After release, the first accepted op appears exactly 3 cycles later.
- ADD 0x3FFFF + 0x00001, cin = 0 → out_sum = 0x00000, cout = 1, ovf = 0, z = 1 (0 without macro).
- SUB 0x00000 − 0x00001, cin = 0 → out_sum = 0x3FFFF, cout = 0, ovf = 0, n = 1. Also SUB 0x00005 − 0x00003, cin = 1 → 0x00001, cout = 1.
- Signed overflow: ADD 0x1FFFF + 0x00001 → out_sum = 0x20000, ovf = 1, cout = 0. SUB 0x20000 − 0x00001 → 0x1FFFF, ovf = 1.
- Backpressure: 10 back-to-back random ops with out_ready = 0 for 4 cycles mid-stream → in_ready low exactly while stalled, results in order with none lost or duplicated, outputs stable while held. A model comparison passes.
- Odd width: WIDTH = 20, SEG_W = 6 (STAGES = 4, last segment 2 bits), ADD 0xFFFFF + 0x00001 → out_sum = 0x00000, cout = 1, latency 4 cycles.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared types and helpers for the segmented pipelined adder/subtractor.
// Used by pipe_addsub and addsub_seg.
package pipe_addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   localparam int DEF_WIDTH = 18;
   localparam int DEF_SEG_W = 6;

   // Number of segments (and pipeline stages) needed to cover width bits.
   function automatic int stages_f(input int width, input int seg_w);
      return (width + seg_w - 1) / seg_w;
   endfunction

endpackage

// File: rtl/addsub_seg.sv
// One pipeline segment: a plain W-bit ripple add of a, b and cin.
// Inversion for subtraction is applied upstream, so this is add-only.
module addsub_seg
   import pipe_addsub_pkg::*;
#(
   parameter int W = DEF_SEG_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement add/sub, one SEG_W-bit segment per stage.
// Optional zero/negative flags are enabled by defining PIPE_ADDSUB_FLAGS_EN.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG_W = DEF_SEG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_z,
   output logic             out_n
);

   localparam int STAGES = stages_f(WIDTH, SEG_W);
   // Depth of the operand/partial-sum registers between stages (min 1 to stay legal).
   localparam int PD     = (STAGES > 1) ? STAGES - 1 : 1;

   logic             stall;
   logic             adv;
   op_e              op;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   logic [STAGES:1]           vld_pipe;
   logic [PD-1:0][WIDTH-1:0]  a_q;
   logic [PD-1:0][WIDTH-1:0]  b_q;
   logic [PD-1:0][WIDTH-1:0]  s_q;
   logic [PD-1:0]             c_q;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   assign stall    = out_valid & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = ~stall;

   // SUB folds into ADD: A + ~B + ~borrow_in.
   assign op    = op_e'(in_op);
   assign b_eff = (op == OP_SUB) ? ~in_b   : in_b;
   assign c_eff = (op == OP_SUB) ? ~in_cin : in_cin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else if (adv) begin
         vld_pipe[1] <= in_valid;
         for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   assign out_valid = vld_pipe[STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int LO = k * SEG_W;
      localparam int SW = (k == STAGES - 1) ? WIDTH - LO : SEG_W;

      logic [WIDTH-1:0] sa;
      logic [WIDTH-1:0] sb;
      logic [WIDTH-1:0] ss;
      logic             sc;
      logic [WIDTH-1:0] sum_nx;
      logic [SW-1:0]    seg_sum;
      logic             seg_cout;

      if (k == 0) begin : g_head
         assign sa = in_a;
         assign sb = b_eff;
         assign sc = c_eff;
         assign ss = '0;
      end else begin : g_body
         assign sa = a_q[k-1];
         assign sb = b_q[k-1];
         assign sc = c_q[k-1];
         assign ss = s_q[k-1];
      end

      addsub_seg #(.W(SW)) u_seg (
         .a    (sa[LO +: SW]),
         .b    (sb[LO +: SW]),
         .cin  (sc),
         .sum  (seg_sum),
         .cout (seg_cout)
      );

      always_comb begin
         sum_nx            = ss;
         sum_nx[LO +: SW]  = seg_sum;
      end

      if (k < STAGES - 1) begin : g_mid
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q[k] <= '0;
               b_q[k] <= '0;
               s_q[k] <= '0;
               c_q[k] <= 1'b0;
            end else if (adv) begin
               a_q[k] <= sa;
               b_q[k] <= sb;
               s_q[k] <= sum_nx;
               c_q[k] <= seg_cout;
            end
         end
      end else begin : g_last
         // Carry into the MSB recovered from the MSB operand and sum bits.
         logic c_msb;
         assign c_msb = sa[WIDTH-1] ^ sb[WIDTH-1] ^ seg_sum[SW-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum_q  <= '0;
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
            end else if (adv) begin
               sum_q  <= sum_nx;
               cout_q <= seg_cout;
               ovf_q  <= c_msb ^ seg_cout;
            end
         end

`ifdef PIPE_ADDSUB_FLAGS_EN
         logic z_q;
         logic n_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               z_q <= 1'b0;
               n_q <= 1'b0;
            end else if (adv) begin
               z_q <= (sum_nx == '0);
               n_q <= sum_nx[WIDTH-1];
            end
         end
         assign out_z = z_q;
         assign out_n = n_q;
`else
         assign out_z = 1'b0;
         assign out_n = 1'b0;
`endif
      end
   end

   // With a single stage the inter-stage registers are never written.
   if (STAGES == 1) begin : g_no_mid
      assign a_q = '0;
      assign b_q = '0;
      assign s_q = '0;
      assign c_q = '0;
   end

   assign out_sum  = sum_q;
   assign out_cout = cout_q;
   assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: default 18/6 instance plus a 20/6 odd-width instance.
module tb_pipe_addsub;
   import pipe_addsub_pkg::*;

`ifdef PIPE_ADDSUB_FLAGS_EN
   localparam logic FL = 1'b1;
`else
   localparam logic FL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 0, in_op = 0, in_cin = 0, out_ready = 1;
   logic [17:0] in_a = '0, in_b = '0;
   logic        in_ready, out_valid, out_cout, out_ovf, out_z, out_n;
   logic [17:0] out_sum;

   logic        v2 = 0, op2 = 0, cin2 = 0, ordy2 = 1;
   logic [19:0] a2 = '0, b2 = '0;
   logic        rdy2, ov2, cout2, ovf2, z2, n2;
   logic [19:0] sum2;

   pipe_addsub u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_z(out_z), .out_n(out_n)
   );

   pipe_addsub #(.WIDTH(20), .SEG_W(6)) u_dut20 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_op(op2),
      .in_a(a2), .in_b(b2), .in_cin(cin2), .out_valid(ov2), .out_ready(ordy2),
      .out_sum(sum2), .out_cout(cout2), .out_ovf(ovf2), .out_z(z2), .out_n(n2)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} for an 18-bit op.
   function automatic logic [19:0] mdl(input logic op, input logic [17:0] a, input logic [17:0] b,
                                       input logic cin);
      logic [17:0] bb;
      logic        c;
      logic [18:0] r;
      logic        ovf;
      bb  = op ? ~b : b;
      c   = op ? ~cin : cin;
      r   = {1'b0, a} + {1'b0, bb} + {18'd0, c};
      ovf = (a[17] == bb[17]) && (r[17] != a[17]);
      return {ovf, r[18], r[17:0]};
   endfunction

   task automatic op_chk(input string tag, input logic op, input logic [17:0] a, input logic [17:0] b,
                         input logic cin, input logic [17:0] es, input logic ec, input logic eo,
                         input logic ez, input logic en);
      int cnt;
      @(negedge clk);
      in_valid = 1; in_op = op; in_a = a; in_b = b; in_cin = cin;
      #1 chk({tag, "/rdy"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!out_valid && cnt < 10);
      chk({tag, "/lat"}, cnt, 3);
      chk({tag, "/sum"}, out_sum, es);
      chk({tag, "/cout"}, out_cout, ec);
      chk({tag, "/ovf"}, out_ovf, eo);
      chk({tag, "/z"}, out_z, ez & FL);
      chk({tag, "/n"}, out_n, en & FL);
   endtask

   initial begin
      logic [19:0] exp_q[$];
      logic [19:0] e;
      logic [19:0] held_v;
      logic        held;
      logic        pend;
      int          sent, got_n, stall_n, cnt;

      // Reset with in_valid asserted: nothing may come out.
      in_valid = 1; in_a = 18'h12345; in_b = 18'h00111; v2 = 1;
      repeat (3) @(negedge clk);
      chk("rst/valid", out_valid, 0);
      chk("rst/sum", out_sum, 0);
      chk("rst/flags", {out_cout, out_ovf, out_z, out_n}, 0);
      chk("rst/in_ready", in_ready, 1);
      chk("rst/valid20", ov2, 0);
      in_valid = 0; v2 = 0;
      rst_n = 1;

      op_chk("add_wrap", 0, 18'h3FFFF, 18'h00001, 0, 18'h00000, 1, 0, 1, 0);
      op_chk("sub_neg",  1, 18'h00000, 18'h00001, 0, 18'h3FFFF, 0, 0, 0, 1);
      op_chk("sub_bin",  1, 18'h00005, 18'h00003, 1, 18'h00001, 1, 0, 0, 0);
      op_chk("add_ovf",  0, 18'h1FFFF, 18'h00001, 0, 18'h20000, 0, 1, 0, 1);
      op_chk("sub_ovf",  1, 18'h20000, 18'h00001, 0, 18'h1FFFF, 1, 1, 0, 0);
      op_chk("add_segc", 0, 18'h3F03F, 18'h00FC1, 0, 18'h00000, 1, 0, 1, 0);
      op_chk("add_cin",  0, 18'h00FFF, 18'h00001, 1, 18'h01001, 0, 0, 0, 0);

      // Backpressure: 10 back-to-back ops, consumer stalls for cycles 6..9.
      repeat (3) @(negedge clk);
      sent = 0; got_n = 0; stall_n = 0; held = 0; held_v = '0; pend = 0;
      for (int cyc = 0; cyc < 60 && got_n < 10; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 6 && cyc < 10);
         #1;
         if (held) begin
            chk("bp/hold_v", out_valid, 1);
            chk("bp/hold", {out_ovf, out_cout, out_sum}, held_v);
         end
         chk("bp/in_ready", in_ready, !(out_valid && cyc >= 6 && cyc < 10));
         if (!in_ready) stall_n++;
         if (out_valid && out_ready) begin
            got_n++;
            if (exp_q.size() == 0) chk("bp/extra", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("bp/res", {out_ovf, out_cout, out_sum}, e);
            end
         end
         held   = out_valid && !out_ready;
         held_v = {out_ovf, out_cout, out_sum};
         if (sent + (pend ? 1 : 0) < 10 && !pend) begin
            in_op = 1'($urandom()); in_a = 18'($urandom()); in_b = 18'($urandom());
            in_cin = 1'($urandom());
            pend = 1;
         end
         in_valid = pend;
         if (pend && in_ready) begin
            exp_q.push_back(mdl(in_op, in_a, in_b, in_cin));
            sent++;
            pend = 0;
         end
      end
      in_valid = 0; out_ready = 1;
      chk("bp/got", got_n, 10);
      chk("bp/sent", sent, 10);
      chk("bp/left", exp_q.size(), 0);
      chk("bp/stall_n", stall_n, 4);

      // Mid-stream reset drops an in-flight op.
      @(negedge clk);
      in_valid = 1; in_op = 0; in_a = 18'h00010; in_b = 18'h00020; in_cin = 0;
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      rst_n = 0;
      #1 chk("mid_rst/valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1;
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("mid_rst/none", cnt, 0);

      // Odd width: 20 bits over 4 stages, last segment 2 bits.
      @(negedge clk);
      v2 = 1; op2 = 0; a2 = 20'hFFFFF; b2 = 20'h00001; cin2 = 0;
      #1 chk("w20/rdy", rdy2, 1);
      @(posedge clk);
      #1 v2 = 0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!ov2 && cnt < 10);
      chk("w20/lat", cnt, 4);
      chk("w20/sum", sum2, 0);
      chk("w20/cout", cout2, 1);
      chk("w20/ovf", ovf2, 0);
      chk("w20/z", z2, FL);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
